// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: channel state encoding,
// default timing constants and counter sizing.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESSED      = 2'd1,
    ST_LONG         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_t;

  localparam int DEFAULT_NUM_SWITCHES = 4;
  localparam int DEFAULT_TICK_DIV     = 25000;
  localparam int DEFAULT_LONG_MS      = 1000;
  localparam int DEFAULT_REPEAT_MS    = 200;
  localparam int DEFAULT_REPEAT_EN    = 1;

  // Bits needed to hold values 0..max_value.
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// One switch channel: press/release/long-press/repeat FSM with its hold
// counter (advanced by the shared tick) and registered event outputs.
module button_event_channel
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_MS   = DEFAULT_LONG_MS,
  parameter int REPEAT_MS = DEFAULT_REPEAT_MS,
  parameter int REPEAT_EN = DEFAULT_REPEAT_EN
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Tick,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_LongPress,
  output logic o_Repeat,
  output logic o_Held
);

  localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int CNT_W    = cnt_width(HOLD_MAX);
  localparam logic [CNT_W-1:0] LONG_VAL   = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] REPEAT_VAL = CNT_W'(REPEAT_MS);

  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next, hold_cnt_inc;
  logic             press_next, release_next, long_next, repeat_next, held_next;

  assign hold_cnt_inc = hold_cnt_reg + CNT_W'(1);

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;
    repeat_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_Switch) begin
          state_next    = ST_PRESSED;
          hold_cnt_next = '0;
          press_next    = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so it wins over a coincident threshold tick.
        if (!i_Switch) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
          release_next  = 1'b1;
        end else if (i_Tick) begin
          if (hold_cnt_inc == LONG_VAL) begin
            state_next    = ST_LONG;
            hold_cnt_next = '0;
            long_next     = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_inc;
          end
        end
      end
      ST_LONG: begin
        if (!i_Switch) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
          release_next  = 1'b1;
        end else if ((REPEAT_EN != 0) && i_Tick) begin
          if (hold_cnt_inc == REPEAT_VAL) begin
            hold_cnt_next = '0;
            repeat_next   = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_inc;
          end
        end
      end
      ST_WAIT_RELEASE: begin
        if (!i_Switch) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    held_next = (state_next != ST_IDLE);
  end

  // Reset parks the channel in WAIT_RELEASE so a switch held through reset
  // must be released before it can generate any event.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg    <= ST_WAIT_RELEASE;
      hold_cnt_reg <= '0;
      o_Press      <= 1'b0;
      o_Release    <= 1'b0;
      o_LongPress  <= 1'b0;
      o_Repeat     <= 1'b0;
      o_Held       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      o_Press      <= press_next;
      o_Release    <= release_next;
      o_LongPress  <= long_next;
      o_Repeat     <= repeat_next;
      o_Held       <= held_next;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Button event decoder top: shared free-running millisecond timebase feeding
// one independent event channel per debounced switch.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int NUM_SWITCHES = DEFAULT_NUM_SWITCHES,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int LONG_MS      = DEFAULT_LONG_MS,
  parameter int REPEAT_MS    = DEFAULT_REPEAT_MS,
  parameter int REPEAT_EN    = DEFAULT_REPEAT_EN
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_SWITCHES-1:0] i_Switches,
  output logic [NUM_SWITCHES-1:0] o_Press,
  output logic [NUM_SWITCHES-1:0] o_Release,
  output logic [NUM_SWITCHES-1:0] o_LongPress,
  output logic [NUM_SWITCHES-1:0] o_Repeat,
  output logic [NUM_SWITCHES-1:0] o_Held
);

  localparam int TICK_W = cnt_width(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_reg;
  logic              tick;

  assign tick = (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_SWITCHES; gi++) begin : g_chan
    button_event_channel #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS),
      .REPEAT_EN (REPEAT_EN)
    ) u_chan (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Tick      (tick),
      .i_Switch    (i_Switches[gi]),
      .o_Press     (o_Press[gi]),
      .o_Release   (o_Release[gi]),
      .o_LongPress (o_LongPress[gi]),
      .o_Repeat    (o_Repeat[gi]),
      .o_Held      (o_Held[gi])
    );
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: two decoders (repeat on/off) driven in parallel,
// checked by vector tables, directed corner cases and a hold-time model.
module tb_button_event_decoder;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int LM = 5;
  localparam int RM = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic [N-1:0] press_a, release_a, long_a, rep_a, held_a;
  logic [N-1:0] press_b, release_b, long_b, rep_b, held_b;

  always #5 clk = ~clk;

  button_event_decoder #(
    .NUM_SWITCHES(N), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM), .REPEAT_EN(1)
  ) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Switches(sw),
    .o_Press(press_a), .o_Release(release_a), .o_LongPress(long_a),
    .o_Repeat(rep_a), .o_Held(held_a)
  );

  button_event_decoder #(
    .NUM_SWITCHES(N), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM), .REPEAT_EN(0)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Switches(sw),
    .o_Press(press_b), .o_Release(release_b), .o_LongPress(long_b),
    .o_Repeat(rep_b), .o_Held(held_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: ticks held since the press (unbounded), plus whether the
  // press is live or suppressed because the switch was held through reset.
  int           since_rst;
  int           m_ticks [2][N];
  bit           m_armed [2][N];
  bit           m_supp  [2][N];
  logic [N-1:0] e_press [2], e_rel [2], e_long [2], e_rep [2], e_held [2];

  task automatic model_edge();
    bit tk;
    tk = 1'b0;
    if (!rst) begin
      tk = ((since_rst % TD) == TD - 1);
      since_rst++;
    end else begin
      since_rst = 0;
    end
    for (int i = 0; i < 2; i++) begin
      e_press[i] = '0; e_rel[i] = '0; e_long[i] = '0; e_rep[i] = '0; e_held[i] = '0;
      for (int c = 0; c < N; c++) begin
        if (rst) begin
          m_supp[i][c]  = 1'b1;
          m_armed[i][c] = 1'b0;
          m_ticks[i][c] = 0;
        end else if (m_supp[i][c]) begin
          if (!sw[c]) m_supp[i][c] = 1'b0;
          else        e_held[i][c] = 1'b1;
        end else if (!m_armed[i][c]) begin
          if (sw[c]) begin
            m_armed[i][c] = 1'b1;
            m_ticks[i][c] = 0;
            e_press[i][c] = 1'b1;
            e_held[i][c]  = 1'b1;
          end
        end else if (!sw[c]) begin
          m_armed[i][c] = 1'b0;
          e_rel[i][c]   = 1'b1;
        end else begin
          e_held[i][c] = 1'b1;
          if (tk) begin
            m_ticks[i][c]++;
            if (m_ticks[i][c] == LM)
              e_long[i][c] = 1'b1;
            else if (i == 0 && m_ticks[i][c] > LM && ((m_ticks[i][c] - LM) % RM) == 0)
              e_rep[i][c] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic bit next_is_tick();
    return (since_rst % TD) == TD - 1;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] s);
    @(negedge clk);
    rst = r;
    sw  = s;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model_a", {press_a, release_a, long_a, rep_a, held_a},
          {e_press[0], e_rel[0], e_long[0], e_rep[0], e_held[0]});
    check("model_b", {press_b, release_b, long_b, rep_b, held_b},
          {e_press[1], e_rel[1], e_long[1], e_rep[1], e_held[1]});
  endtask

  typedef struct packed {
    logic         rst;
    logic [N-1:0] sw;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] rep;
    logic [N-1:0] held;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   press_at, long_at, nlong_a, nlong_b, nrep_b, tick_count;
    int   reps[$];
    bit   done;

    rst = 1'b1;
    sw  = '0;
    since_rst = 0;

    // Short press on bit0, concurrent press/release, reset mid-hold.
    tbl.push_back({1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1});
    for (int k = 0; k < 7; k++)
      tbl.push_back({1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1});
    tbl.push_back({1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back({1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back({1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back({1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back({1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back({1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back({1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].sw);
      check($sformatf("vec%0d", i), {press_a, release_a, long_a, rep_a, held_a},
            {tbl[i].press, tbl[i].rel, tbl[i].lng, tbl[i].rep, tbl[i].held});
      $display("[TB] vec%0d rst=%b sw=%h press=%h rel=%h long=%h rep=%h held=%h",
               i, tbl[i].rst, tbl[i].sw, press_a, release_a, long_a, rep_a, held_a);
    end

    // Long hold on bit1 for 60 cycles, both repeat settings.
    press_at = -1; long_at = -1; nlong_a = 0; nlong_b = 0; nrep_b = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b0, 4'b0010);
      if (press_a[1]) press_at = cyc;
      if (long_a[1]) begin nlong_a++; long_at = cyc; end
      if (rep_a[1]) reps.push_back(cyc);
      if (long_b[1]) nlong_b++;
      if (rep_b[1]) nrep_b++;
    end
    step(1'b0, 4'b0000);
    check("long_release_a", 20'(release_a), 20'(4'b0010));
    check("long_release_b", 20'(release_b), 20'(4'b0010));
    check_int("long_count_a", nlong_a, 1);
    check_int("long_count_b", nlong_b, 1);
    check_int("repeat_count_b", nrep_b, 0);
    check_int("press_to_long_17_20", int'((long_at - press_at) >= 17 && (long_at - press_at) <= 20), 1);
    check_int("repeat_count_a_ge3", int'(reps.size() >= 3), 1);
    if (reps.size() > 0) check_int("long_to_repeat", reps[0] - long_at, 12);
    for (int k = 1; k < reps.size(); k++)
      check_int("repeat_gap", reps[k] - reps[k-1], 12);
    $display("[TB] long hold: press@%0d long@%0d repeats=%0d", press_at, long_at, reps.size());

    // Release of bit2 on the very tick that would reach LONG_MS.
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    check("collide_press", 20'(press_a), 20'(4'b0100));
    tick_count = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (next_is_tick() && tick_count == LM - 1) begin
        step(1'b0, 4'b0000);
        check("collide_release", {release_a, long_a, release_b, long_b},
              {4'b0100, 4'b0000, 4'b0100, 4'b0000});
        done = 1'b1;
      end else begin
        if (next_is_tick()) tick_count++;
        step(1'b0, 4'b0100);
        check("collide_no_early_long", 20'(long_a), 20'(0));
      end
    end
    check_int("collide_reached", int'(done), 1);
    $display("[TB] collision: release=%h long=%h", release_a, long_a);

    // Bit3 held through reset produces no events until released.
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1000);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b1000);
      check("held_thru_rst_quiet", {press_a, release_a, long_a, rep_a}, 20'(0));
    end
    step(1'b0, 4'b0000);
    check("held_thru_rst_fall", {press_a, release_a}, 20'(0));
    step(1'b0, 4'b1000);
    check("held_thru_rst_press", 20'(press_a), 20'(4'b1000));
    step(1'b0, 4'b0000);
    $display("[TB] held through reset: press after re-press=%h", press_a);

    // Random stimulus with long holds and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] nsw;
      logic         nrst;
      nsw = sw;
      for (int c = 0; c < N; c++)
        if ($urandom_range(39, 0) == 0) nsw[c] = ~nsw[c];
      nrst = ($urandom_range(599, 0) == 0);
      step(nrst, nsw);
    end
    $display("[TB] random: %0d cycles done", 4000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
